// File: rtl/fc_3_argmax.sv
// fc_3_argmax: captures the fc_3 logit vector on a rising edge of fc_3_finish, scans it
// serially for the signed maximum and hands the winning class to the host over valid/ready.
// Build option: define ARGMAX_TOP2_EN to also report the runner-up index and best-second margin.
module fc_3_argmax #(
  parameter int N_CLASS = 10,
  parameter int DW      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fc_3_en,
  input  logic                  fc_3_finish,
  input  logic [N_CLASS*DW-1:0] result_10x16,
  input  logic                  class_rdy,
  output logic                  class_vld,
  output logic [3:0]            class_id,
  output logic [DW-1:0]         class_score,
  output logic                  busy,
  output logic                  overrun
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [3:0]            class_id2,
  output logic [DW:0]           margin
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_CLASS - 1);

  state_t               r_state;
  logic                 r_finish_d;
  logic                 r_en_d;
  logic [3:0]           r_idx;
  logic signed [DW-1:0] r_vec [N_CLASS];
  logic signed [DW-1:0] r_best;
  logic [3:0]           r_best_idx;
  logic                 r_class_vld;
  logic [3:0]           r_class_id;
  logic [DW-1:0]        r_class_score;
  logic                 r_busy;
  logic                 r_overrun;

  logic                 w_fin_p;
  logic                 w_en_rise;
  logic signed [DW-1:0] w_cand;
  logic signed [DW-1:0] w_best_nx;
  logic [3:0]           w_best_idx_nx;

`ifdef ARGMAX_TOP2_EN
  logic signed [DW-1:0] r_sec;
  logic [3:0]           r_sec_idx;
  logic                 r_sec_vld;
  logic [3:0]           r_class_id2;
  logic [DW:0]          r_margin;
  logic signed [DW-1:0] w_sec_nx;
  logic [3:0]           w_sec_idx_nx;
  logic [DW:0]          w_margin_nx;
`endif

  assign w_fin_p   = fc_3_finish & ~r_finish_d;
  assign w_en_rise = fc_3_en & ~r_en_d;
  assign w_cand    = r_vec[r_idx];

  // One candidate per cycle; strict compare so ties stay with the lower index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_best_nx     = r_best;
    w_best_idx_nx = r_best_idx;
`ifdef ARGMAX_TOP2_EN
    w_sec_nx      = r_sec;
    w_sec_idx_nx  = r_sec_idx;
`endif
    if (w_cand > r_best) begin
      w_best_nx     = w_cand;
      w_best_idx_nx = r_idx;
`ifdef ARGMAX_TOP2_EN
      w_sec_nx      = r_best;
      w_sec_idx_nx  = r_best_idx;
`endif
    end
`ifdef ARGMAX_TOP2_EN
    else if (!r_sec_vld || (w_cand > r_sec)) begin
      w_sec_nx     = w_cand;
      w_sec_idx_nx = r_idx;
    end
    // Sign-extend both operands so the difference never overflows.
    w_margin_nx = {w_best_nx[DW-1], w_best_nx} - {w_sec_nx[DW-1], w_sec_nx};
`endif
  end

  // NOTE: the logit buffer is pure datapath and is never read before CAPTURE fills it,
  // so it has no reset and lives in its own clock-only block.
  always_ff @(posedge clk) begin
    if (r_state == S_CAPTURE) begin
      for (int i = 0; i < N_CLASS; i++) begin
        r_vec[i] <= result_10x16[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_finish_d    <= 1'b0;
      r_en_d        <= 1'b0;
      r_idx         <= '0;
      r_best        <= '0;
      r_best_idx    <= '0;
      r_class_vld   <= 1'b0;
      r_class_id    <= '0;
      r_class_score <= '0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef ARGMAX_TOP2_EN
      r_sec         <= '0;
      r_sec_idx     <= '0;
      r_sec_vld     <= 1'b0;
      r_class_id2   <= '0;
      r_margin      <= '0;
`endif
    end else begin
      r_finish_d <= fc_3_finish;
      r_en_d     <= fc_3_en;

      // A finish edge in any non-idle state (including the DONE handshake cycle) is lost.
      if (w_en_rise) begin
        r_overrun <= 1'b0;
      end else if (w_fin_p && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      if (!fc_3_en) begin
        r_state     <= S_IDLE;
        r_class_vld <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_fin_p) begin
              r_state <= S_CAPTURE;
              r_busy  <= 1'b1;
            end
          end

          S_CAPTURE: begin
            r_best     <= result_10x16[DW-1:0];
            r_best_idx <= '0;
            r_idx      <= 4'd1;
`ifdef ARGMAX_TOP2_EN
            r_sec_vld  <= 1'b0;
`endif
            r_state    <= S_SCAN;
          end

          S_SCAN: begin
            r_best     <= w_best_nx;
            r_best_idx <= w_best_idx_nx;
            r_idx      <= r_idx + 4'd1;
`ifdef ARGMAX_TOP2_EN
            r_sec      <= w_sec_nx;
            r_sec_idx  <= w_sec_idx_nx;
            r_sec_vld  <= 1'b1;
`endif
            if (r_idx == LAST_IDX) begin
              r_state       <= S_DONE;
              r_class_vld   <= 1'b1;
              r_class_id    <= w_best_idx_nx;
              r_class_score <= w_best_nx;
`ifdef ARGMAX_TOP2_EN
              r_class_id2   <= w_sec_idx_nx;
              r_margin      <= w_margin_nx;
`endif
            end
          end

          S_DONE: begin
            if (class_rdy) begin
              r_state     <= S_IDLE;
              r_class_vld <= 1'b0;
              r_busy      <= 1'b0;
            end
          end

          default: begin
            r_state     <= S_IDLE;
            r_class_vld <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign class_vld   = r_class_vld;
  assign class_id    = r_class_id;
  assign class_score = r_class_score;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
`ifdef ARGMAX_TOP2_EN
  assign class_id2   = r_class_id2;
  assign margin      = r_margin;
`endif

endmodule
